// File: rtl/level_matrix_scan_pkg.sv
// level_matrix_scan_pkg: mode encodings, default level width and the bar lookup
// shared by the LED matrix level display.
package level_matrix_scan_pkg;

    localparam logic [1:0] MODE_SLOW = 2'd0;
    localparam logic [1:0] MODE_MID  = 2'd1;
    localparam logic [1:0] MODE_FAST = 2'd2;

    localparam int LEVEL_W_DEF = 3;

    // Returns {red, green} for row i of a bottom-filled bar of height min(lvl+2, rows).
    function automatic logic [1:0] bar_rg(
        input int lvl,
        input int i,
        input int rows,
        input int warn,
        input int alarm
    );
        int h;
        h = (lvl + 2 < rows) ? lvl + 2 : rows;
        if (i < rows - h) return 2'b00;
        return (lvl < warn) ? 2'b01 : (lvl < alarm) ? 2'b11 : 2'b10;
    endfunction

endpackage

// File: rtl/level_matrix_scan_tick_gen.sv
// level_matrix_scan_tick_gen: counter 0..lim with sync clear; tick is high on
// the cycle the count sits at lim (suppressed while clearing).
module level_matrix_scan_tick_gen #(
    parameter  int DIV = 2,
    localparam int W   = $clog2(DIV)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] lim,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = !clr && cnt == lim;

    always_ff @(posedge clk) begin
        if (!rst || clr) cnt <= '0;
        else cnt <= (cnt == lim) ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/level_matrix_scan.sv
// level_matrix_scan: scans a ROWS x COLS bicolour LED matrix as a water-level
// bar graph, with overflow blink, selectable blink rate and a level-driven beeper.
module level_matrix_scan
    import level_matrix_scan_pkg::*;
#(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int LEVEL_W     = LEVEL_W_DEF,
    parameter int WARN_LEVEL  = 1,
    parameter int ALARM_LEVEL = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_DIV   = 500000,
    parameter int TONE_DIV    = 2500,
    parameter int CADENCE_DIV = 2000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level,
    input  logic               mode_pulse,
    output logic [ROWS-1:0]    row,
    output logic [COLS-1:0]    col_r,
    output logic [COLS-1:0]    col_g,
    output logic               beeper,
    output logic [1:0]         mode,
    output logic               frame_start
);

    localparam int TOP = (1 << LEVEL_W) - 1;
    localparam int RW  = $clog2(ROWS);
    localparam int SW  = $clog2(SCAN_DIV);
    localparam int BW  = $clog2(BLINK_DIV);
    localparam int TW  = $clog2(TONE_DIV);
    localparam int CW  = $clog2(CADENCE_DIV);

    if (!(WARN_LEVEL >= 1 && WARN_LEVEL <= ALARM_LEVEL && ALARM_LEVEL < TOP)) begin : g_bad_level
        $error("level_matrix_scan: need 1 <= WARN_LEVEL <= ALARM_LEVEL < 2^LEVEL_W-1");
    end
    if (ROWS < 2) begin : g_bad_rows
        $error("level_matrix_scan: ROWS must be at least 2");
    end
    if (SCAN_DIV < 2 || BLINK_DIV < 2 || TONE_DIV < 2 || CADENCE_DIV < 2) begin : g_bad_div
        $error("level_matrix_scan: all divisors must be at least 2");
    end

    logic [RW-1:0]      idx;
    logic [LEVEL_W-1:0] lvl_q;
    logic               scan_t, blink_t, tone_t, cad_t;
    logic               blink_ph, tone_ph, cad_ph;
    logic               wrap, ovf, bp;
    logic [1:0]         rg;
    logic [BW-1:0]      blink_lim;

    level_matrix_scan_tick_gen #(.DIV(SCAN_DIV)) u_scan (
        .clk(clk), .rst(rst), .clr(1'b0), .lim(SW'(SCAN_DIV - 1)), .tick(scan_t)
    );
    // Clearing on every mode pulse makes a new blink rate take effect at once.
    level_matrix_scan_tick_gen #(.DIV(BLINK_DIV)) u_blink (
        .clk(clk), .rst(rst), .clr(mode_pulse), .lim(blink_lim), .tick(blink_t)
    );
    level_matrix_scan_tick_gen #(.DIV(TONE_DIV)) u_tone (
        .clk(clk), .rst(rst), .clr(1'b0), .lim(TW'(TONE_DIV - 1)), .tick(tone_t)
    );
    level_matrix_scan_tick_gen #(.DIV(CADENCE_DIV)) u_cad (
        .clk(clk), .rst(rst), .clr(1'b0), .lim(CW'(CADENCE_DIV - 1)), .tick(cad_t)
    );

    always_comb begin
        wrap      = scan_t && idx == RW'(ROWS - 1);
        ovf       = lvl_q == LEVEL_W'(TOP);
        rg        = ovf ? {blink_ph, 1'b0}
                        : bar_rg(int'(lvl_q), int'(idx), ROWS, WARN_LEVEL, ALARM_LEVEL);
        bp        = ovf ? tone_ph & blink_ph
                  : (lvl_q >= LEVEL_W'(ALARM_LEVEL)) ? tone_ph
                  : (lvl_q != '0) ? tone_ph & cad_ph : 1'b0;
        blink_lim = BW'(((BLINK_DIV >> mode) > 1) ? (BLINK_DIV >> mode) - 1 : 0);
    end

    // Outputs are built from the current row index and snapshot together, so
    // row and columns always stay aligned.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx         <= '0;
            lvl_q       <= '0;
            mode        <= MODE_SLOW;
            blink_ph    <= 1'b0;
            tone_ph     <= 1'b0;
            cad_ph      <= 1'b0;
            row         <= '1;
            col_r       <= '0;
            col_g       <= '0;
            beeper      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (scan_t) idx <= wrap ? '0 : idx + 1'b1;
            if (wrap) lvl_q <= level;
            frame_start <= wrap;
            if (mode_pulse) mode <= (mode == MODE_SLOW) ? MODE_MID : (mode == MODE_MID) ? MODE_FAST : MODE_SLOW;
            if (blink_t) blink_ph <= ~blink_ph;
            if (tone_t) tone_ph <= ~tone_ph;
            if (cad_t) cad_ph <= ~cad_ph;
            row    <= ~(ROWS'(1) << idx);
            col_r  <= {COLS{rg[1]}};
            col_g  <= {COLS{rg[0]}};
            beeper <= bp;
        end
    end

endmodule
